sample_feeder: RTL and testbench
================================

// Module: sample_feeder
// PURPOSE
//  Upstream stage for the four-sample averager. Buffers 16-bit samples from a
//  producer (valid/ready) in a small FIFO and presents them one at a time on
//  sample_data/data_ready. Each sample is handshaked against the averager's
//  modwait; the averager synchronizes data_ready internally.
// PARAMETERS
//  DEPTH        4    FIFO entries, power of 2, >= 2
//  ACK_TIMEOUT  16   cycles data_ready may stay high without modwait before abort
// PORTS
//  clk          in   1   system clock, rising edge
//  n_reset      in   1   asynchronous active-low reset
//  in_valid     in   1   producer has a sample on in_data
//  in_data      in   16  producer sample
//  in_ready     out  1   FIFO can accept; write occurs when in_valid && in_ready
//  modwait      in   1   averager busy flag (from the averager's modwait output)
//  sample_data  out  16  sample presented to the averager
//  data_ready   out  1   sample_data valid; level, held until acknowledged
//  overrun      out  1   sticky: in_valid seen while FIFO full
//  ack_timeout  out  1   one-cycle pulse: presentation aborted, sample dropped
//  sent_count   out  10  [SAMPLE_COUNT_EN only] delivered-sample counter
// BEHAVIOUR
//  Reset (async, n_reset=0): state IDLE, FIFO empty, sample_data=16'h0000,
//   data_ready=0, in_ready=1, overrun=0, ack_timeout=0, sent_count=0.
//   Reset mid-handshake discards the presented sample and all FIFO contents.
//  FIFO: wr/rd pointers of log2(DEPTH)+1 bits; full = MSBs differ, low bits equal.
//   in_ready = !full (registered-state derived, no in_valid path).
//   Write and pop in the same cycle are legal when not full; count unchanged.
//   When full, in_ready=0 and in_valid is ignored even if a pop occurs that cycle.
//  overrun: set on any cycle with in_valid && full; cleared only by reset.
//  FSM:
//   IDLE    : data_ready=0. If FIFO non-empty && modwait==0: load head into
//             sample_data, pop, clear timer -> PRESENT.
//   PRESENT : data_ready=1, timer++ each cycle. If modwait==1 -> ACKED.
//             Else if timer == ACK_TIMEOUT-1: pulse ack_timeout -> IDLE.
//             modwait==1 takes priority over timeout in the same cycle.
//   ACKED   : data_ready=0; sent_count++ on entry. Wait modwait==0 -> IDLE.
//  sample_data is stable from the load edge until the next load (not cleared).
//  Latency: sample accepted at edge N into empty FIFO, IDLE, modwait=0 ->
//   data_ready=1 and sample_data valid after edge N+2.
//  Min sample spacing: 1 IDLE cycle between ACKED exit and next PRESENT.
//  Timer width: $clog2(ACK_TIMEOUT)+1; no wrap possible.
// CONFIGURATION
//  SAMPLE_COUNT_EN defined: sent_count present; increments on each PRESENT->ACKED,
//   wraps 999 -> 0 (matches the averager's 1000-sample framing).
//  Not defined: sent_count port and counter absent; all else identical.
// STRUCTURE
//  feeder_pkg: DATA_W=16 localparam; typedef enum logic [1:0]
//   {IDLE, PRESENT, ACKED} feeder_state_t; COUNT_WRAP=10'd999.
//  One sub-module: sample_fifo (DEPTH, DATA_W) holding storage, pointers,
//   full/empty; FSM, timer, overrun and counter stay in sample_feeder.
// TESTING
//  1 Reset: hold n_reset=0 with in_valid=1 -> all outputs at reset values,
//    nothing written; release -> in_ready=1.
//  2 Single sample 16'hA5A5, modwait=0 -> data_ready high 2 edges later,
//    sample_data=16'hA5A5; raise modwait 3 cycles later -> data_ready low next
//    edge; drop modwait -> IDLE, FIFO empty.
//  3 Burst 5 writes (16'h0001..16'h0005), modwait=1 held -> first 4 accepted,
//    in_ready=0, 5th sets overrun=1; release -> samples 1..4 delivered in order.
//  4 Never assert modwait -> data_ready high exactly 16 cycles, ack_timeout
//    pulses 1 cycle, next FIFO entry presented after 1 IDLE cycle.
//  5 Simultaneous write and pop at count=2 -> count stays 2, in_ready stays 1;
//    modwait rises on timer==15 -> ACKED, no ack_timeout.
//  6 SAMPLE_COUNT_EN: deliver 1001 samples -> sent_count 999 -> 0 -> 1;
//    async reset asserted in PRESENT -> data_ready=0 immediately, count=0.

Source files
------------

// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared types and constants for the sample feeder
package feeder_pkg;
    localparam int DATA_W = 16;
    localparam logic [9:0] COUNT_WRAP = 10'd999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACKED   = 2'd2
    } feeder_state_t;
endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - small power-of-two FIFO with extra-MSB pointers
module sample_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (wr_en && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en && !empty) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observable behind the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - FIFO-buffered sample presenter with modwait handshake
// Optional delivered-sample counter enabled by SAMPLE_COUNT_EN.
module sample_feeder
    import feeder_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              modwait,
    output logic [DATA_W-1:0] sample_data,
    output logic              data_ready,
    output logic              overrun,
    output logic              ack_timeout
`ifdef SAMPLE_COUNT_EN
    ,
    output logic [9:0]        sent_count
`endif
);
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    feeder_state_t     state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              avail_q, avail_d;
    logic              overrun_q, overrun_d;
    logic              ack_q, ack_d;
    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    sample_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .wr_en   (in_valid && !fifo_full),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready    = !fifo_full;
    assign data_ready  = (state_q == PRESENT);
    assign sample_data = sample_q;
    assign overrun     = overrun_q;
    assign ack_timeout = ack_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        sample_d  = sample_q;
        ack_d     = 1'b0;
        pop       = 1'b0;
        // The head is offered one cycle after it lands, giving two-edge latency.
        avail_d   = !fifo_empty;
        overrun_d = overrun_q | (in_valid & fifo_full);
        case (state_q)
            IDLE: begin
                if (avail_q && !modwait) begin
                    sample_d = fifo_head;
                    pop      = 1'b1;
                    timer_d  = '0;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                if (modwait) begin
                    state_d = ACKED;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ACKED: begin
                if (!modwait) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            sample_q  <= '0;
            avail_q   <= 1'b0;
            overrun_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sample_q  <= sample_d;
            avail_q   <= avail_d;
            overrun_q <= overrun_d;
            ack_q     <= ack_d;
        end
    end

`ifdef SAMPLE_COUNT_EN
    logic [9:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == PRESENT && modwait) begin
            count_d = (count_q == COUNT_WRAP) ? 10'd0 : count_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sent_count = count_q;
`endif
endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - self-checking bench for sample_feeder (SAMPLE_COUNT_EN aware)
module tb_sample_feeder;
    localparam int DEPTH       = 4;
    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        modwait;
    logic [15:0] sample_data;
    logic        data_ready;
    logic        overrun;
    logic        ack_timeout;
`ifdef SAMPLE_COUNT_EN
    logic [9:0]  sent_count;
`endif

    sample_feeder #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .modwait     (modwait),
        .sample_data (sample_data),
        .data_ready  (data_ready),
        .overrun     (overrun),
        .ack_timeout (ack_timeout)
`ifdef SAMPLE_COUNT_EN
        ,
        .sent_count  (sent_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of accepted samples plus the presentation status.
    logic [15:0] mq[$];
    bit          m_present, m_hold, m_seen, m_ack, m_overrun;
    int          m_age;
    logic [15:0] m_sd;
    int          m_sent_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_present = 0; m_hold = 0; m_seen = 0; m_ack = 0; m_overrun = 0;
        m_age = 0; m_sd = 16'h0000; m_sent_total = 0;
    endtask

    task automatic model_edge(input logic v, input logic [15:0] d, input logic mw);
        bit pre_nonempty;
        bit full;
        pre_nonempty = (mq.size() > 0);
        full = (mq.size() == DEPTH);
        m_ack = 0;
        if (v && full) m_overrun = 1;
        if (m_present) begin
            if (mw) begin
                m_present = 0; m_hold = 1; m_sent_total++;
            end else if (m_age == ACK_TIMEOUT - 1) begin
                m_present = 0; m_ack = 1;
            end else begin
                m_age++;
            end
        end else if (m_hold) begin
            if (!mw) m_hold = 0;
        end else if (m_seen && !mw && mq.size() > 0) begin
            m_sd = mq.pop_front();
            m_present = 1;
            m_age = 0;
        end
        if (v && !full) mq.push_back(d);
        m_seen = pre_nonempty;
    endtask

    task automatic check_all();
        chk("data_ready", data_ready, m_present);
        chk("sample_data", sample_data, m_sd);
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("overrun", overrun, m_overrun);
        chk("ack_timeout", ack_timeout, m_ack);
`ifdef SAMPLE_COUNT_EN
        chk("sent_count", sent_count, m_sent_total % 1000);
`endif
    endtask

    task automatic cycle(input logic v, input logic [15:0] d, input logic mw);
        in_valid = v; in_data = d; modwait = mw;
        @(posedge clk);
        model_edge(v, d, mw);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        n_reset = 1'b0; in_valid = 1'b1; in_data = 16'hDEAD; modwait = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_data_ready", data_ready, 1'b0);
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_sample", sample_data, 16'h0000);
        n_reset = 1'b1; in_valid = 1'b0;
    endtask

    task automatic wait_dr();
        int n = 0;
        while (!data_ready && n < 40) begin
            cycle(1'b0, 16'h0, 1'b0);
            n++;
        end
        chk("wait_data_ready", data_ready, 1'b1);
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        mw;
        logic        e_dr;
        logic [15:0] e_sd;
        logic        e_rdy;
    } vec_t;

    vec_t tbl[9];
    int   hi;
    int   n;
    int   mark;
    bit   silent;

    initial begin
        n_reset = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF; modwait = 1'b0;
        model_reset();
        //            v     d          mw    dr    sample     rdy
        tbl[0] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5, 1'b1};
        tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5, 1'b1};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5, 1'b1};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hA5A5, 1'b1};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hA5A5, 1'b1};
        tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'hA5A5, 1'b1};
        tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'hA5A5, 1'b1};

        @(negedge clk);
        // Reset held with in_valid high: nothing may be written.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b0);
        chk("post_rst_no_sample", data_ready, 1'b0);

        // Single sample handshake.
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].mw);
            chk($sformatf("t2_dr[%0d]", i), data_ready, tbl[i].e_dr);
            chk($sformatf("t2_sd[%0d]", i), sample_data, tbl[i].e_sd);
            chk($sformatf("t2_rdy[%0d]", i), in_ready, tbl[i].e_rdy);
        end

        // Burst into a stalled averager: fifth write overruns.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 16'(k), 1'b1);
            if (k == 4) begin
                chk("t3_full_rdy", in_ready, 1'b0);
                chk("t3_no_overrun_yet", overrun, 1'b0);
            end
        end
        chk("t3_overrun", overrun, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            wait_dr();
            chk($sformatf("t3_order[%0d]", k), sample_data, 16'(k));
            cycle(1'b0, 16'h0, 1'b1);
            cycle(1'b0, 16'h0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b0);
        chk("t3_drained", data_ready, 1'b0);
        chk("t3_overrun_sticky", overrun, 1'b1);

        // Timeout: modwait never rises.
        do_reset();
        cycle(1'b1, 16'hB001, 1'b0);
        cycle(1'b1, 16'hB002, 1'b0);
        hi = 0; n = 0;
        while (!ack_timeout && n < 40) begin
            cycle(1'b0, 16'h0, 1'b0);
            if (data_ready) hi++;
            n++;
        end
        chk("t4_ack_seen", ack_timeout, 1'b1);
        chk("t4_high_cycles", hi, ACK_TIMEOUT);
        chk("t4_dr_at_ack", data_ready, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        chk("t4_ack_width", ack_timeout, 1'b0);
        chk("t4_next_dr", data_ready, 1'b1);
        chk("t4_next_sample", sample_data, 16'hB002);

        // Write and pop together at count 2, then late acknowledge.
        do_reset();
        cycle(1'b1, 16'hC001, 1'b1);
        cycle(1'b1, 16'hC002, 1'b1);
        cycle(1'b1, 16'hC003, 1'b0);
        chk("t5_pop_dr", data_ready, 1'b1);
        chk("t5_pop_sample", sample_data, 16'hC001);
        chk("t5_rdy_after_pop", in_ready, 1'b1);
        cycle(1'b1, 16'hC004, 1'b0);
        chk("t5_rdy_count3", in_ready, 1'b1);
        cycle(1'b1, 16'hC005, 1'b0);
        chk("t5_rdy_count4", in_ready, 1'b0);
        hi = 3; n = 0;
        while (hi < ACK_TIMEOUT && n < 30) begin
            cycle(1'b0, 16'h0, 1'b0);
            if (data_ready) hi++;
            n++;
        end
        chk("t5_last_cycle_dr", data_ready, 1'b1);
        cycle(1'b0, 16'h0, 1'b1);
        chk("t5_acked_dr", data_ready, 1'b0);
        chk("t5_no_ack_timeout", ack_timeout, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        chk("t5_no_ack_timeout2", ack_timeout, 1'b0);
        wait_dr();
        chk("t5_next_sample", sample_data, 16'hC002);

        // Randomized traffic against the model, alternating responsive and silent averager.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            silent = ((i / 150) % 2) == 1;
            cycle(1'($urandom_range(0, 1)), 16'($urandom),
                  silent ? 1'b0 : 1'($urandom_range(0, 2) == 0));
        end

`ifdef SAMPLE_COUNT_EN
        do_reset();
        n = 0; mark = 0;
        while (m_sent_total < 1001 && n < 6000) begin
            cycle(in_ready, 16'(n), data_ready);
            n++;
            if (m_sent_total == 999 && mark == 0) begin
                chk("t6_count_999", sent_count, 10'd999); mark = 1;
            end else if (m_sent_total == 1000 && mark == 1) begin
                chk("t6_count_wrap", sent_count, 10'd0); mark = 2;
            end else if (m_sent_total == 1001 && mark == 2) begin
                chk("t6_count_1", sent_count, 10'd1); mark = 3;
            end
        end
        chk("t6_all_marks", mark, 3);
`endif

        // Asynchronous reset while a sample is presented.
        do_reset();
        cycle(1'b1, 16'hE00E, 1'b0);
        wait_dr();
        #2;
        do_reset();
        chk("t6_rst_in_present_dr", data_ready, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b0);
        chk("t6_fifo_discarded", data_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
